// File: rtl/z3_dma_master.sv
// z3_dma_master: Zorro III bus-master cycle generator for single longword DMA transfers.
// Optional WAIT timeout enabled by defining Z3_MASTER_TIMEOUT_EN.
module z3_dma_master #(
    parameter int ADDR_SETUP     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req,
    input  logic [29:0] req_addr,
    input  logic        req_write,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        BR_n,
    input  logic        BG_n,
    input  logic        FCS_n_in,
    input  logic        DTACK_n,
    input  logic        BERR_n,
    input  logic [31:0] D_in,
    output logic [31:0] ADDR_OUT,
    output logic [31:0] D_OUT,
    output logic        FCS_n,
    output logic [3:0]  DS_n,
    output logic        DOE,
    output logic        READ,
    output logic        MASTER,
    output logic        DATA_OE
);
    typedef enum logic [2:0] {IDLE, ARB, ADDR, STRB, WAIT, TERM, REL} state_t;
    localparam logic [7:0] SETUP_LAST = 8'(ADDR_SETUP - 1);
    if (ADDR_SETUP < 1 || ADDR_SETUP > 256 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("z3_dma_master: parameter out of range");
    end
    state_t      state_q, state_d;
    logic [1:0]  bg_q, fcs_q, dtack_q, berr_q;
    logic        bg_s, fcs_s, dtack_s, berr_s;
    logic [29:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  setup_q, setup_d;
    logic        br_n_q, br_n_d, fcs_n_q, fcs_n_d, doe_q, doe_d, read_q, read_d;
    logic        master_q, master_d, data_oe_q, data_oe_d;
    logic        ack_q, ack_d, err_q, err_d, busy_q, busy_d;
    logic [3:0]  ds_n_q, ds_n_d;
    logic [31:0] rdata_q, rdata_d, addr_out_q, addr_out_d, d_out_q, d_out_d;
`ifdef Z3_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  tcnt_q, tcnt_d;
`endif
    assign bg_s    = bg_q[1];
    assign fcs_s   = fcs_q[1];
    assign dtack_s = dtack_q[1];
    assign berr_s  = berr_q[1];
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        setup_d    = setup_q;
        br_n_d     = br_n_q;
        fcs_n_d    = fcs_n_q;
        ds_n_d     = ds_n_q;
        doe_d      = doe_q;
        read_d     = read_q;
        master_d   = master_q;
        data_oe_d  = data_oe_q;
        ack_d      = 1'b0;
        err_d      = err_q;
        busy_d     = busy_q;
        rdata_d    = rdata_q;
        addr_out_d = addr_out_q;
        d_out_d    = d_out_q;
`ifdef Z3_MASTER_TIMEOUT_EN
        tcnt_d     = tcnt_q;
`endif
        case (state_q)
            IDLE: if (req) begin
                addr_d  = req_addr;
                write_d = req_write;
                be_d    = req_be;
                wdata_d = req_wdata;
                busy_d  = 1'b1;
                br_n_d  = 1'b0;
                state_d = ARB;
            end
            // Take the bus only once granted and the previous owner has fully let go.
            ARB: if (!bg_s && fcs_s && dtack_s) begin
                br_n_d     = 1'b1;
                master_d   = 1'b1;
                read_d     = ~write_q;
                addr_out_d = {addr_q, 2'b00};
                setup_d    = 8'd0;
                state_d    = ADDR;
            end
            ADDR: if (setup_q == SETUP_LAST) begin
                fcs_n_d = 1'b0;
                state_d = STRB;
            end else begin
                setup_d = setup_q + 8'd1;
            end
            STRB: begin
                doe_d   = 1'b1;
                ds_n_d  = ~be_q;
                if (write_q) begin
                    data_oe_d = 1'b1;
                    d_out_d   = wdata_q;
                end
`ifdef Z3_MASTER_TIMEOUT_EN
                tcnt_d  = 8'd0;
`endif
                state_d = WAIT;
            end
            WAIT: if (!berr_s) begin
                err_d   = 1'b1;
                state_d = TERM;
            end else if (!dtack_s) begin
                if (!write_q) rdata_d = D_in;
                state_d = TERM;
            end
`ifdef Z3_MASTER_TIMEOUT_EN
            else begin
                tcnt_d = tcnt_q + 8'd1;
                if (tcnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = TERM;
                end
            end
`endif
            TERM: begin
                fcs_n_d = 1'b1;
                ds_n_d  = 4'hF;
                doe_d   = 1'b0;
                ack_d   = 1'b1;
                state_d = REL;
            end
            REL: if (dtack_s && berr_s) begin
                master_d  = 1'b0;
                data_oe_d = 1'b0;
                read_d    = 1'b1;
                busy_d    = 1'b0;
                err_d     = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            bg_q       <= 2'b11;
            fcs_q      <= 2'b11;
            dtack_q    <= 2'b11;
            berr_q     <= 2'b11;
            addr_q     <= '0;
            write_q    <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            setup_q    <= '0;
            br_n_q     <= 1'b1;
            fcs_n_q    <= 1'b1;
            ds_n_q     <= 4'hF;
            doe_q      <= 1'b0;
            read_q     <= 1'b1;
            master_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= '0;
            addr_out_q <= '0;
            d_out_q    <= '0;
`ifdef Z3_MASTER_TIMEOUT_EN
            tcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bg_q       <= {bg_q[0], BG_n};
            fcs_q      <= {fcs_q[0], FCS_n_in};
            dtack_q    <= {dtack_q[0], DTACK_n};
            berr_q     <= {berr_q[0], BERR_n};
            addr_q     <= addr_d;
            write_q    <= write_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            setup_q    <= setup_d;
            br_n_q     <= br_n_d;
            fcs_n_q    <= fcs_n_d;
            ds_n_q     <= ds_n_d;
            doe_q      <= doe_d;
            read_q     <= read_d;
            master_q   <= master_d;
            data_oe_q  <= data_oe_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            rdata_q    <= rdata_d;
            addr_out_q <= addr_out_d;
            d_out_q    <= d_out_d;
`ifdef Z3_MASTER_TIMEOUT_EN
            tcnt_q     <= tcnt_d;
`endif
        end
    end
    assign ack      = ack_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign BR_n     = br_n_q;
    assign ADDR_OUT = addr_out_q;
    assign D_OUT    = d_out_q;
    assign FCS_n    = fcs_n_q;
    assign DS_n     = ds_n_q;
    assign DOE      = doe_q;
    assign READ     = read_q;
    assign MASTER   = master_q;
    assign DATA_OE  = data_oe_q;
endmodule
